// File: rtl/single_clock_mips_pkg.sv
// Shared opcode/funct encodings and the ALU operation set for the single-cycle MIPS core.
`timescale 1ns/1ps
package single_clock_mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   // Wrapping 32-bit ALU; slt compares as signed.
   function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] y;
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
         default: y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/single_clock_mips_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, cleared on reset.
`timescale 1ns/1ps
module single_clock_mips_regfile
   import single_clock_mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs_reg [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs_reg[wa] <= wd;
      end
   end

   // $0 is hardwired regardless of array contents.
   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_reg[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_reg[ra2];

endmodule

// File: rtl/single_clock_mips.sv
// Single-cycle MIPS subset with instruction-load mode; IMEM/DMEM survive reset.
// Optional feature: define SINGLE_CLOCK_MIPS_JUMP_EN to enable the j instruction.
`timescale 1ns/1ps
module single_clock_mips
   import single_clock_mips_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] W_Ins,
   input  logic        WE,
   output logic [31:0] PC,
   output logic [31:0] Result
);

   logic [31:0] imem_reg [64];
   logic [31:0] dmem_reg [64];
   logic [5:0]  wptr_reg;
   logic [31:0] pc_reg, pc_next, pc_plus4;
   logic [31:0] instr, sext_imm, rs_val, rt_val, ea;
   logic [31:0] result_next, wd;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wa;
   logic        reg_we, dmem_we, exec;
   alu_op_e     alu_op;
   logic        unused_bits;

   assign exec     = RST && !WE;
   assign instr    = imem_reg[pc_reg[7:2]];
   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign sext_imm = {{16{instr[15]}}, instr[15:0]};
   assign pc_plus4 = pc_reg + 32'd4;
   assign ea       = rs_val + sext_imm;
   assign unused_bits = ^{instr[10:6], ea[31:8], ea[1:0]};

   single_clock_mips_regfile u_regfile (
      .clk   (CLK),
      .rst_n (RST),
      .ra1   (rs),
      .ra2   (rt),
      .we    (reg_we && !WE),
      .wa    (wa),
      .wd    (wd),
      .rd1   (rs_val),
      .rd2   (rt_val)
   );

   always_comb begin
      pc_next     = pc_plus4;
      result_next = '0;
      reg_we      = 1'b0;
      dmem_we     = 1'b0;
      wa          = rd;
      wd          = '0;
      alu_op      = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            reg_we = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: reg_we = 1'b0;
            endcase
            if (reg_we) result_next = alu(alu_op, rs_val, rt_val);
            wd = result_next;
         end
         OP_ADDI: begin
            result_next = alu(ALU_ADD, rs_val, sext_imm);
            reg_we      = 1'b1;
            wa          = rt;
            wd          = result_next;
         end
         OP_LW: begin
            result_next = dmem_reg[ea[7:2]];
            reg_we      = 1'b1;
            wa          = rt;
            wd          = result_next;
         end
         OP_SW: begin
            result_next = ea;
            dmem_we     = 1'b1;
         end
         OP_BEQ: begin
            result_next = alu(ALU_SUB, rs_val, rt_val);
            if (rs_val == rt_val) pc_next = pc_plus4 + {sext_imm[29:0], 2'b00};
         end
`ifdef SINGLE_CLOCK_MIPS_JUMP_EN
         OP_J: begin
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc_reg   <= '0;
         wptr_reg <= '0;
      end else if (WE) begin
         wptr_reg <= wptr_reg + 6'd1;
      end else begin
         pc_reg <= pc_next;
      end
   end

   // Memories carry no reset so a loaded program and its data outlive RST; writes are
   // still suppressed while RST is low so a reset aborts the in-flight store/load.
   always_ff @(posedge CLK) begin
      if (WE && RST) imem_reg[wptr_reg] <= W_Ins;
   end

   always_ff @(posedge CLK) begin
      if (dmem_we && exec) dmem_reg[ea[7:2]] <= rt_val;
   end

   assign PC     = pc_reg;
   assign Result = exec ? result_next : 32'd0;

endmodule

// File: tb/tb_single_clock_mips.sv
// Directed self-checking bench for single_clock_mips (load, reset, ALU, memory, branch, jump).
`timescale 1ns/1ps
module tb_single_clock_mips;

   logic        CLK = 1'b0;
   logic        RST;
   logic        WE;
   logic [31:0] W_Ins;
   logic [31:0] PC;
   logic [31:0] Result;
   int          n_checks = 0;
   int          n_pass   = 0;

   single_clock_mips dut (
      .CLK    (CLK),
      .RST    (RST),
      .W_Ins  (W_Ins),
      .WE     (WE),
      .PC     (PC),
      .Result (Result)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [31:0] w);
      WE    = 1'b1;
      W_Ins = w;
      tick();
   endtask

   task automatic run();
      WE = 1'b0;
      #1;
   endtask

   task automatic restart();
      RST = 1'b0;
      #1;
      check("rst_pc", PC, 32'd0);
      check("rst_result", Result, 32'd0);
      RST = 1'b1;
      #1;
   endtask

   // Check the current instruction's Result, then let it retire.
   task automatic step(input string tag, input logic [31:0] exp);
      check(tag, Result, exp);
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog PC=0x%08h", PC);
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b0; WE = 1'b1; W_Ins = 32'd0;
      #0.4;
      check("por_pc", PC, 32'd0);
      check("por_result", Result, 32'd0);
      #0.1;
      RST = 1'b1;

      // Fill IMEM with nops; wptr wraps back to 0.
      repeat (64) load(32'd0);
      check("load_pc_hold", PC, 32'd0);
      check("load_result", Result, 32'd0);
      run();
      tick();
      check("first_exec_pc", PC, 32'd4);
      check("nop_result", Result, 32'd0);

      // Load addi/add, then reset and execute.
      load(32'h20010005);
      load(32'h00211020);
      check("load_mode_result", Result, 32'd0);
      check("load_mode_pc", PC, 32'd4);
      run();
      restart();
      step("addi_5", 32'd5);
      check("pc_after_1", PC, 32'd4);
      step("add_10", 32'd10);
      check("pc_after_2", PC, 32'd8);

      // Memory: sw then lw, observe $3 through add.
      restart();
      load(32'h20010005);
      load(32'hAC010008);
      load(32'h8C030008);
      load(32'h00602820);
      run();
      step("mem_addi", 32'd5);
      step("sw_ea", 32'd8);
      step("lw_data", 32'd5);
      step("add_from_lw", 32'd5);

      // ALU ops, unknown funct, signed slt, register 0.
      restart();
      load(32'h2001FFFD);
      load(32'h20020006);
      load(32'h00222022);
      load(32'h00222024);
      load(32'h00222025);
      load(32'h00222021);
      load(32'h00802820);
      load(32'h0022202A);
      load(32'h0041202A);
      load(32'h20000007);
      load(32'h00002020);
      run();
      step("addi_neg", 32'hFFFFFFFD);
      step("addi_6", 32'd6);
      step("sub", 32'hFFFFFFF7);
      step("and", 32'd4);
      step("or", 32'hFFFFFFFF);
      step("bad_funct", 32'd0);
      step("no_write_bad_funct", 32'hFFFFFFFF);
      step("slt_signed_true", 32'd1);
      step("slt_signed_false", 32'd0);
      step("addi_r0", 32'd7);
      step("add_r0_r0", 32'd0);
      check("alu_prog_pc", PC, 32'h2C);

      // Branch: not-taken beq, then beq-to-self at 0x10.
      restart();
      load(32'h20010001);
      load(32'h10200005);
      load(32'd0);
      load(32'd0);
      load(32'h1000FFFF);
      run();
      step("br_addi", 32'd1);
      step("beq_not_taken", 32'd1);
      check("beq_nt_pc", PC, 32'd8);
      step("br_nop0", 32'd0);
      step("br_nop1", 32'd0);
      check("beq_reach_pc", PC, 32'h10);
      for (int i = 0; i < 3; i++) begin
         step("beq_self_result", 32'd0);
         check("beq_self_pc", PC, 32'h10);
      end

      // Jump: behaviour depends on the build option.
      restart();
      load(32'h08000003);
      run();
      step("j_result", 32'd0);
`ifdef SINGLE_CLOCK_MIPS_JUMP_EN
      check("j_pc", PC, 32'h0000000C);
`else
      check("j_pc", PC, 32'd4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
